// File: rtl/term_ctrl.sv
// Character-terminal controller: turns a byte stream into VRAM writes, cursor moves,
// and built-in scroll, clear and erase sequences on a single-port character VRAM.
module term_ctrl #(
    parameter int unsigned COLS  = 60,
    parameter int unsigned ROWS  = 17,
    parameter int unsigned COL_W = 6,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned TAB   = 8,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ectlchrs,
    input  logic                   i_autowrap,
    input  logic [7:0]             i_char,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [ROW_W-1:0]       o_cur_row,
    output logic [COL_W-1:0]       o_cur_col,
    output logic [ROW_W+COL_W-1:0] o_vram_addr,
    output logic [7:0]             o_vram_din,
    input  logic [7:0]             i_vram_dout,
    output logic                   o_vram_clk,
    output logic                   o_vram_ce,
    output logic                   o_vram_wre
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] PEN_ROW  = ROW_W'(ROWS - 2);
    localparam logic [COL_W:0]   TAB_MASK = (COL_W + 1)'(TAB - 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, WRITE, SCROLL_RD, SCROLL_WR, FILL, WAIT_ROW, WAIT_COL
    } state_t;

    state_t           state;
    logic [7:0]       ch;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             ready;
    logic             ce;
    logic             wre;
    logic [ROW_W-1:0] addr_row;
    logic [COL_W-1:0] addr_col;
    logic [7:0]       din_q;
    logic [ROW_W-1:0] sc_row;
    logic [ROW_W-1:0] fill_end;

    logic             is_ctl;
    logic [7:0]       pos;
    logic [ROW_W-1:0] row_from_char;
    logic [COL_W-1:0] col_from_char;
    logic [COL_W:0]   tab_sum;
    logic [COL_W-1:0] tab_col;

    always_comb begin
        unique case (ch)
            8'h00, 8'h07, 8'h08, 8'h7F, 8'h09, 8'h0A, 8'h0B,
            8'h0C, 8'h0D, 8'h18, 8'h14: is_ctl = 1'b1;
            default:                    is_ctl = 1'b0;
        endcase
    end

    // Position bytes are offset by 0x20; values below 0x20 wrap high and saturate.
    always_comb begin
        pos = i_char - 8'h20;
        row_from_char = ({24'd0, pos} > (ROWS - 1)) ? LAST_ROW : ROW_W'(pos);
        col_from_char = ({24'd0, pos} > (COLS - 1)) ? LAST_COL : COL_W'(pos);
        tab_sum = ({1'b0, cur_col} | TAB_MASK) + (COL_W + 1)'(1);
        tab_col = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[COL_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            ch       <= 8'h00;
            cur_row  <= '0;
            cur_col  <= '0;
            ready    <= 1'b1;
            ce       <= 1'b0;
            wre      <= 1'b0;
            addr_row <= '0;
            addr_col <= '0;
            din_q    <= 8'h00;
            sc_row   <= '0;
            fill_end <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        ch    <= i_char;
                        state <= DECODE;
                        ready <= 1'b0;
                    end
                end
                DECODE: begin
                    if (i_ectlchrs && is_ctl) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        case (ch)
                            8'h08, 8'h7F: if (cur_col != '0) cur_col <= cur_col - COL_W'(1);
                            8'h09: cur_col <= tab_col;
                            8'h0A: begin
                                if (cur_row == LAST_ROW) begin
                                    state    <= SCROLL_RD;
                                    ready    <= 1'b0;
                                    ce       <= 1'b1;
                                    wre      <= 1'b0;
                                    addr_row <= ROW_W'(1);
                                    addr_col <= '0;
                                    sc_row   <= '0;
                                end else begin
                                    cur_row <= cur_row + ROW_W'(1);
                                end
                            end
                            8'h0B: if (cur_row != '0) cur_row <= cur_row - ROW_W'(1);
                            8'h0C: begin
                                cur_row  <= '0;
                                cur_col  <= '0;
                                state    <= FILL;
                                ready    <= 1'b0;
                                ce       <= 1'b1;
                                wre      <= 1'b1;
                                din_q    <= BLANK;
                                addr_row <= '0;
                                addr_col <= '0;
                                fill_end <= LAST_ROW;
                            end
                            8'h0D: cur_col <= '0;
                            8'h18: begin
                                state    <= FILL;
                                ready    <= 1'b0;
                                ce       <= 1'b1;
                                wre      <= 1'b1;
                                din_q    <= BLANK;
                                addr_row <= cur_row;
                                addr_col <= cur_col;
                                fill_end <= cur_row;
                            end
                            8'h14: state <= WAIT_ROW;
                            default: ;
                        endcase
                    end else begin
                        state    <= WRITE;
                        ce       <= 1'b1;
                        wre      <= 1'b1;
                        addr_row <= cur_row;
                        addr_col <= cur_col;
                        din_q    <= ch;
                    end
                end
                WRITE: begin
                    ce    <= 1'b0;
                    wre   <= 1'b0;
                    state <= IDLE;
                    ready <= 1'b1;
                    if (cur_col != LAST_COL) begin
                        cur_col <= cur_col + COL_W'(1);
                    end else if (i_autowrap) begin
                        cur_col <= '0;
                        if (cur_row != LAST_ROW) begin
                            cur_row <= cur_row + ROW_W'(1);
                        end else begin
                            state    <= SCROLL_RD;
                            ready    <= 1'b0;
                            ce       <= 1'b1;
                            addr_row <= ROW_W'(1);
                            addr_col <= '0;
                            sc_row   <= '0;
                        end
                    end
                end
                SCROLL_RD: begin
                    state    <= SCROLL_WR;
                    wre      <= 1'b1;
                    addr_row <= sc_row;
                end
                SCROLL_WR: begin
                    wre <= 1'b0;
                    if (addr_col != LAST_COL) begin
                        state    <= SCROLL_RD;
                        addr_row <= sc_row + ROW_W'(1);
                        addr_col <= addr_col + COL_W'(1);
                    end else if (sc_row != PEN_ROW) begin
                        state    <= SCROLL_RD;
                        sc_row   <= sc_row + ROW_W'(1);
                        addr_row <= sc_row + ROW_W'(2);
                        addr_col <= '0;
                    end else begin
                        // Last row copied; blank the bottom row.
                        state    <= FILL;
                        wre      <= 1'b1;
                        din_q    <= BLANK;
                        addr_row <= LAST_ROW;
                        addr_col <= '0;
                        fill_end <= LAST_ROW;
                    end
                end
                FILL: begin
                    if (addr_col != LAST_COL) begin
                        addr_col <= addr_col + COL_W'(1);
                    end else if (addr_row != fill_end) begin
                        addr_row <= addr_row + ROW_W'(1);
                        addr_col <= '0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        ce    <= 1'b0;
                        wre   <= 1'b0;
                    end
                end
                WAIT_ROW: begin
                    if (i_valid) begin
                        cur_row <= row_from_char;
                        state   <= WAIT_COL;
                    end
                end
                WAIT_COL: begin
                    if (i_valid) begin
                        cur_col <= col_from_char;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready     = ready;
    assign o_cur_row   = cur_row;
    assign o_cur_col   = cur_col;
    assign o_vram_addr = {addr_row, addr_col};
    // Scroll writes forward the word read in the previous cycle straight through.
    assign o_vram_din  = (state == SCROLL_WR) ? i_vram_dout : din_q;
    assign o_vram_clk  = i_clk;
    assign o_vram_ce   = ce;
    assign o_vram_wre  = wre;

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl with a behavioural VRAM; unwritten cells read a fixed pattern.
module tb_term_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ectl = 1'b1;
    logic        awrap = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  chr = 8'h00;
    logic        ready;
    logic [4:0]  cur_row;
    logic [5:0]  cur_col;
    logic [10:0] vaddr;
    logic [7:0]  vdin;
    logic [7:0]  vdout = 8'h00;
    logic        vclk;
    logic        ce;
    logic        wre;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:2047];
    bit          mem_v [0:2047];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          bad_col = 0;
    logic [10:0] last_wa = '0;

    term_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ectlchrs  (ectl),
        .i_autowrap  (awrap),
        .i_char      (chr),
        .i_valid     (valid),
        .o_ready     (ready),
        .o_cur_row   (cur_row),
        .o_cur_col   (cur_col),
        .o_vram_addr (vaddr),
        .o_vram_din  (vdin),
        .i_vram_dout (vdout),
        .o_vram_clk  (vclk),
        .o_vram_ce   (ce),
        .o_vram_wre  (wre)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [10:0] a);
        logic [6:0] t;
        t = 7'(a[10:6]) * 7'd5 + 7'(a[5:0]);
        return {1'b1, t};
    endfunction

    function automatic logic [7:0] rd(input logic [10:0] a);
        return mem_v[a] ? mem[a] : pat(a);
    endfunction

    function automatic logic [10:0] aa(input int r, input int c);
        return 11'(r * 64 + c);
    endfunction

    always @(posedge clk) begin
        if (ce) begin
            if (vaddr[5:0] >= 6'd60) bad_col <= bad_col + 1;
            if (wre) begin
                mem[vaddr]   <= vdin;
                mem_v[vaddr] <= 1'b1;
                wr_cnt       <= wr_cnt + 1;
                last_wa      <= vaddr;
            end else begin
                vdout  <= rd(vaddr);
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (ready !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chr = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Called in cycle 1 after the accept edge; n is the cycle where ready is seen high.
    task automatic wait_idle(input int maxc, output int n);
        n = 1;
        while (ready !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic move(input int r, input int c);
        send(8'h14);
        send(8'(r + 32));
        send(8'(c + 32));
    endtask

    initial begin
        int n;
        int w0;
        int r0;
        int err;
        logic [7:0] e;

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_wre", 32'(wre), 32'd0);
        chk("rst_addr", 32'(vaddr), 32'd0);
        chk("rst_din", 32'(vdin), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("vram_clk", 32'(vclk), 32'(clk));

        // Printable 'A' at (0,0)
        send(8'h41);
        chk("a_c1_ready", 32'(ready), 32'd0);
        chk("a_c1_ce", 32'(ce), 32'd0);
        @(negedge clk);
        chk("a_c2_ce", 32'(ce), 32'd1);
        chk("a_c2_wre", 32'(wre), 32'd1);
        chk("a_c2_addr", 32'(vaddr), 32'd0);
        chk("a_c2_din", 32'(vdin), 32'h41);
        chk("a_c2_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("a_c3_ready", 32'(ready), 32'd1);
        chk("a_c3_ce", 32'(ce), 32'd0);
        chk("a_mem", 32'(rd(aa(0, 0))), 32'h41);
        chk("a_row", 32'(cur_row), 32'd0);
        chk("a_col", 32'(cur_col), 32'd1);

        // Direct positioning with saturation and wrap-around
        move(5, 27);
        chk("pos1_ready", 32'(ready), 32'd1);
        chk("pos1_row", 32'(cur_row), 32'd5);
        chk("pos1_col", 32'(cur_col), 32'd27);
        send(8'h14);
        send(8'h7F);
        send(8'h10);
        chk("pos2_row", 32'(cur_row), 32'd16);
        chk("pos2_col", 32'(cur_col), 32'd59);

        // Autowrap at bottom-right triggers a scroll
        awrap = 1'b1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        send(8'h5A);
        wait_idle(4000, n);
        chk("scroll_lat", 32'(n), 32'd1983);
        chk("scroll_writes", 32'(wr_cnt - w0), 32'd1021);
        chk("scroll_reads", 32'(rd_cnt - r0), 32'd960);
        chk("scroll_row", 32'(cur_row), 32'd16);
        chk("scroll_col", 32'(cur_col), 32'd0);
        chk("scroll_z", 32'(rd(aa(15, 59))), 32'h5A);
        err = 0;
        for (int r = 0; r < 17; r++) begin
            for (int c = 0; c < 60; c++) begin
                if (r < 15) e = pat(aa(r + 1, c));
                else if (r == 15) e = (c == 59) ? 8'h5A : pat(aa(16, c));
                else e = 8'h20;
                if (rd(aa(r, c)) !== e) err++;
            end
        end
        chk("scroll_mem", 32'(err), 32'd0);

        // Autowrap off: cursor sticks at last column
        move(16, 59);
        awrap = 1'b0;
        w0 = wr_cnt;
        send(8'h5A);
        wait_idle(10, n);
        chk("nowrap_lat", 32'(n), 32'd3);
        chk("nowrap_writes", 32'(wr_cnt - w0), 32'd1);
        chk("nowrap_row", 32'(cur_row), 32'd16);
        chk("nowrap_col", 32'(cur_col), 32'd59);
        chk("nowrap_mem", 32'(rd(aa(16, 59))), 32'h5A);
        awrap = 1'b1;

        // Erase to end of line
        move(3, 50);
        w0 = wr_cnt;
        send(8'h18);
        wait_idle(100, n);
        chk("erase_lat", 32'(n), 32'd12);
        chk("erase_writes", 32'(wr_cnt - w0), 32'd10);
        chk("erase_last", 32'(last_wa), 32'(aa(3, 59)));
        chk("erase_row", 32'(cur_row), 32'd3);
        chk("erase_col", 32'(cur_col), 32'd50);
        err = 0;
        for (int c = 50; c < 60; c++) if (rd(aa(3, c)) !== 8'h20) err++;
        chk("erase_mem", 32'(err), 32'd0);
        chk("erase_keep", 32'(rd(aa(3, 49))), 32'(pat(aa(4, 49))));

        // Tab, CR, backspace, LF, VT
        move(3, 57);
        send(8'h09);
        wait_idle(10, n);
        chk("tab_lat", 32'(n), 32'd2);
        chk("tab_sat", 32'(cur_col), 32'd59);
        move(3, 3);
        send(8'h09);
        wait_idle(10, n);
        chk("tab_mid", 32'(cur_col), 32'd8);
        send(8'h0D);
        wait_idle(10, n);
        chk("cr_col", 32'(cur_col), 32'd0);
        send(8'h08);
        wait_idle(10, n);
        chk("bs_lat", 32'(n), 32'd2);
        chk("bs_sat", 32'(cur_col), 32'd0);
        send(8'h0A);
        wait_idle(10, n);
        chk("lf_row", 32'(cur_row), 32'd4);
        move(0, 0);
        send(8'h0B);
        wait_idle(10, n);
        chk("vt_sat", 32'(cur_row), 32'd0);

        // Clear screen with valid held high throughout
        move(7, 9);
        w0 = wr_cnt;
        r0 = bad_col;
        chr = 8'h0C;
        valid = 1'b1;
        @(negedge clk);
        chr = 8'h42;
        n = 1;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("clr_lat", 32'(n), 32'd1022);
        chk("clr_writes", 32'(wr_cnt - w0), 32'd1020);
        chk("clr_cols", 32'(bad_col - r0), 32'd0);
        chk("clr_row", 32'(cur_row), 32'd0);
        chk("clr_col", 32'(cur_col), 32'd0);
        err = 0;
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 60; c++)
                if (rd(aa(r, c)) !== 8'h20) err++;
        chk("clr_mem", 32'(err), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        wait_idle(10, n);
        chk("held_lat", 32'(n), 32'd3);
        chk("held_mem", 32'(rd(aa(0, 0))), 32'h42);
        chk("held_col", 32'(cur_col), 32'd1);

        // Reset in the middle of a scroll
        move(16, 59);
        send(8'h51);
        repeat (101) @(negedge clk);
        chk("mid_ce", 32'(ce), 32'd1);
        chk("mid_wre", 32'(wre), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ce", 32'(ce), 32'd0);
        chk("abort_wre", 32'(wre), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_row", 32'(cur_row), 32'd0);
        chk("abort_col", 32'(cur_col), 32'd0);
        chk("abort_addr", 32'(vaddr), 32'd0);

        // Control interpretation off: 0A is printed
        ectl = 1'b0;
        send(8'h0A);
        wait_idle(10, n);
        chk("raw_lat", 32'(n), 32'd3);
        chk("raw_mem", 32'(rd(aa(0, 0))), 32'h0A);
        chk("raw_row", 32'(cur_row), 32'd0);
        chk("raw_col", 32'(cur_col), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
